// File: rtl/sys_defs.sv
// Definitions shared between the CAM and its controllers.
// The command encoding must stay identical to the one the CAM decodes.
package sys_defs;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } COMMAND;

  localparam int unsigned KEY_W = 32;

endpackage

// File: rtl/cam_rr_alloc.sv
// Round-robin victim pointer for CAM inserts, plus a count of slots filled since reset.
// The pointer wraps at SIZE rather than 2**IDX_W, so non-power-of-two CAMs are handled.
module cam_rr_alloc #(
  parameter  int unsigned SIZE  = 8,
  localparam int unsigned IDX_W = $clog2(SIZE),
  localparam int unsigned OCC_W = IDX_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  output logic [IDX_W-1:0] ptr,
  output logic [OCC_W-1:0] occupancy
);

  logic [IDX_W-1:0] ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic [IDX_W-1:0] ptr_nxt_s;
  logic [OCC_W-1:0] occ_nxt_s;

  // Next victim slot and saturating fill count for one insert.
  always_comb begin
    ptr_nxt_s = ptr_r;
    occ_nxt_s = occ_r;
    if (advance) begin
      if (ptr_r == IDX_W'(SIZE - 1)) begin
        ptr_nxt_s = {IDX_W{1'b0}};
      end else begin
        ptr_nxt_s = ptr_r + IDX_W'(1);
      end
      if (occ_r < OCC_W'(SIZE)) begin
        occ_nxt_s = occ_r + OCC_W'(1);
      end else begin
        occ_nxt_s = occ_r;
      end
    end else begin
      ptr_nxt_s = ptr_r;
      occ_nxt_s = occ_r;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r <= {IDX_W{1'b0}};
      occ_r <= {OCC_W{1'b0}};
    end else begin
      ptr_r <= ptr_nxt_s;
      occ_r <= occ_nxt_s;
    end
  end

  assign ptr       = ptr_r;
  assign occupancy = occ_r;

endmodule

// File: rtl/cam_lookup_ctrl.sv
// Initiator for one CAM: lookup on request, insert into a round-robin victim slot on a
// miss when asked, and return a single response per request over a valid/ready pair.
module cam_lookup_ctrl
  import sys_defs::*;
#(
  parameter  int unsigned SIZE  = 8,
  localparam int unsigned IDX_W = $clog2(SIZE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_data,
  input  logic             req_insert,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic             rsp_inserted,
  output logic [IDX_W-1:0] rsp_idx,
  output logic [IDX_W:0]   occupancy,
  output logic             cam_enable,
  output COMMAND           cam_command,
  output logic [IDX_W-1:0] cam_write_idx,
  output logic [31:0]      cam_data,
  input  logic             cam_hit,
  input  logic [IDX_W-1:0] cam_read_idx
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic             insert_r, insert_nxt_s;
  logic             req_ready_r, req_ready_nxt_s;
  logic             rsp_valid_r, rsp_valid_nxt_s;
  logic             rsp_hit_r, rsp_hit_nxt_s;
  logic             rsp_inserted_r, rsp_inserted_nxt_s;
  logic [IDX_W-1:0] rsp_idx_r, rsp_idx_nxt_s;
  logic             cam_enable_r, cam_enable_nxt_s;
  COMMAND           cam_command_r, cam_command_nxt_s;
  logic [IDX_W-1:0] cam_write_idx_r, cam_write_idx_nxt_s;
  logic [31:0]      cam_data_r, cam_data_nxt_s;
  logic [IDX_W-1:0] ptr_s;
  logic             advance_s;

  // The victim slot is consumed on the edge that completes the CAM write.
  assign advance_s = (state_r == ST_WRITE);

  cam_rr_alloc #(
    .SIZE (SIZE)
  ) u_alloc (
    .clock     (clock),
    .reset     (reset),
    .advance   (advance_s),
    .ptr       (ptr_s),
    .occupancy (occupancy)
  );

  // Next state plus the next value of every registered output.
  always_comb begin
    state_nxt_s         = state_r;
    insert_nxt_s        = insert_r;
    req_ready_nxt_s     = 1'b0;
    rsp_valid_nxt_s     = rsp_valid_r;
    rsp_hit_nxt_s       = rsp_hit_r;
    rsp_inserted_nxt_s  = rsp_inserted_r;
    rsp_idx_nxt_s       = rsp_idx_r;
    cam_enable_nxt_s    = 1'b0;
    cam_command_nxt_s   = READ;
    cam_write_idx_nxt_s = cam_write_idx_r;
    cam_data_nxt_s      = cam_data_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt_s      = ST_LOOKUP;
          insert_nxt_s     = req_insert;
          cam_data_nxt_s   = req_data;
          cam_enable_nxt_s = 1'b1;
        end else begin
          req_ready_nxt_s = 1'b1;
        end
      end
      ST_LOOKUP: begin
        // A resident key always takes the hit path, so it is never written twice.
        if (cam_hit) begin
          state_nxt_s        = ST_RESP;
          rsp_valid_nxt_s    = 1'b1;
          rsp_hit_nxt_s      = 1'b1;
          rsp_inserted_nxt_s = 1'b0;
          rsp_idx_nxt_s      = cam_read_idx;
        end else if (insert_r) begin
          state_nxt_s         = ST_WRITE;
          cam_enable_nxt_s    = 1'b1;
          cam_command_nxt_s   = WRITE;
          cam_write_idx_nxt_s = ptr_s;
        end else begin
          state_nxt_s        = ST_RESP;
          rsp_valid_nxt_s    = 1'b1;
          rsp_hit_nxt_s      = 1'b0;
          rsp_inserted_nxt_s = 1'b0;
          rsp_idx_nxt_s      = {IDX_W{1'b0}};
        end
      end
      ST_WRITE: begin
        state_nxt_s        = ST_RESP;
        rsp_valid_nxt_s    = 1'b1;
        rsp_hit_nxt_s      = 1'b0;
        rsp_inserted_nxt_s = 1'b1;
        rsp_idx_nxt_s      = ptr_s;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s     = ST_IDLE;
          rsp_valid_nxt_s = 1'b0;
          req_ready_nxt_s = 1'b1;
        end else begin
          state_nxt_s     = ST_RESP;
          rsp_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        rsp_valid_nxt_s = 1'b0;
        req_ready_nxt_s = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      insert_r        <= 1'b0;
      req_ready_r     <= 1'b1;
      rsp_valid_r     <= 1'b0;
      rsp_hit_r       <= 1'b0;
      rsp_inserted_r  <= 1'b0;
      rsp_idx_r       <= {IDX_W{1'b0}};
      cam_enable_r    <= 1'b0;
      cam_command_r   <= READ;
      cam_write_idx_r <= {IDX_W{1'b0}};
      cam_data_r      <= 32'h0000_0000;
    end else begin
      state_r         <= state_nxt_s;
      insert_r        <= insert_nxt_s;
      req_ready_r     <= req_ready_nxt_s;
      rsp_valid_r     <= rsp_valid_nxt_s;
      rsp_hit_r       <= rsp_hit_nxt_s;
      rsp_inserted_r  <= rsp_inserted_nxt_s;
      rsp_idx_r       <= rsp_idx_nxt_s;
      cam_enable_r    <= cam_enable_nxt_s;
      cam_command_r   <= cam_command_nxt_s;
      cam_write_idx_r <= cam_write_idx_nxt_s;
      cam_data_r      <= cam_data_nxt_s;
    end
  end

  assign req_ready     = req_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_hit       = rsp_hit_r;
  assign rsp_inserted  = rsp_inserted_r;
  assign rsp_idx       = rsp_idx_r;
  assign cam_enable    = cam_enable_r;
  assign cam_command   = cam_command_r;
  assign cam_write_idx = cam_write_idx_r;
  assign cam_data      = cam_data_r;

endmodule
